// File: rtl/disaster_monitor_seq.sv
// disaster_monitor_seq: quantises four sensor streams, filters hazard conditions
// with persistence/clear hysteresis, and drives registered LEDs plus a latched alarm.
module disaster_monitor_seq #(
  parameter int unsigned DW      = 7,
  parameter int unsigned R_T1    = 2,
  parameter int unsigned R_T2    = 10,
  parameter int unsigned R_T3    = 31,
  parameter int unsigned S_T1    = 2,
  parameter int unsigned S_T2    = 6,
  parameter int unsigned S_T3    = 16,
  parameter int unsigned W_T1    = 16,
  parameter int unsigned W_T2    = 30,
  parameter int unsigned W_T3    = 61,
  parameter int unsigned L_T1    = 6,
  parameter int unsigned L_T2    = 20,
  parameter int unsigned L_T3    = 51,
  parameter int unsigned PERSIST = 4,
  parameter int unsigned CLEAR   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] rain,
  input  logic [DW-1:0] seismic,
  input  logic [DW-1:0] wind,
  input  logic [DW-1:0] sea,
  input  logic          mode,
  input  logic          ack,
  output logic          flood_led,
  output logic          cyclone_led,
  output logic          earthquake_led,
  output logic          tsunami_led,
  output logic          danger_led,
  output logic          safe_led,
  output logic          alarm,
  output logic [7:0]    alarm_count
);

  localparam int unsigned MAX_PC = (PERSIST > CLEAR) ? PERSIST : CLEAR;
  localparam int unsigned CW     = $clog2(MAX_PC + 1);
  localparam int unsigned NH     = 4;  // 0 flood, 1 cyclone, 2 earthquake, 3 tsunami

  // Map a reading onto a 2-bit severity level against three ascending thresholds.
  function automatic logic [1:0] quant(input logic [DW-1:0] x,
                                       input logic [DW-1:0] t1,
                                       input logic [DW-1:0] t2,
                                       input logic [DW-1:0] t3);
    if (x >= t3)      return 2'd3;
    else if (x >= t2) return 2'd2;
    else if (x >= t1) return 2'd1;
    else              return 2'd0;
  endfunction

  logic [1:0] r_lvl_q, s_lvl_q, w_lvl_q, l_lvl_q;
  logic       vld_q;

  logic [NH-1:0]         raw_c;
  logic [NH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NH-1:0]         conf_q, conf_d;
  logic [CW-1:0]         inc_c, lim_c;

  logic [NH-1:0] led_q, led_d;
  logic          danger_q, danger_d;
  logic          alarm_q, alarm_d;
  logic [7:0]    cnt_alarm_q, cnt_alarm_d;
  logic          onset_c;

  // Stage 1: capture sensor levels on valid samples; delay the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_q <= 2'd0;
      s_lvl_q <= 2'd0;
      w_lvl_q <= 2'd0;
      l_lvl_q <= 2'd0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= sample_valid;
      if (sample_valid) begin
        r_lvl_q <= quant(rain,    DW'(R_T1), DW'(R_T2), DW'(R_T3));
        s_lvl_q <= quant(seismic, DW'(S_T1), DW'(S_T2), DW'(S_T3));
        w_lvl_q <= quant(wind,    DW'(W_T1), DW'(W_T2), DW'(W_T3));
        l_lvl_q <= quant(sea,     DW'(L_T1), DW'(L_T2), DW'(L_T3));
      end
    end
  end

  // Raw hazard conditions derived from the registered levels.
  always_comb begin
    raw_c    = '0;
    raw_c[0] = (r_lvl_q >= 2'd2) && ((w_lvl_q >= 2'd2) || (l_lvl_q >= 2'd2) || (r_lvl_q == 2'd3));
    raw_c[1] = (w_lvl_q >= 2'd2) && ((w_lvl_q == 2'd3) || (l_lvl_q >= 2'd2) || (r_lvl_q >= 2'd2));
    raw_c[2] = (s_lvl_q >= 2'd1);
    raw_c[3] = (s_lvl_q == 2'd3) || (l_lvl_q >= 2'd2);
  end

  // Stage 2 next-state: per-hazard streak counter toggling the confirmed flag.
  always_comb begin
    cnt_d  = cnt_q;
    conf_d = conf_q;
    inc_c  = '0;
    lim_c  = '0;
    if (vld_q) begin
      for (int i = 0; i < NH; i++) begin
        inc_c = cnt_q[i] + CW'(1);
        lim_c = conf_q[i] ? CW'(CLEAR) : CW'(PERSIST);
        if (raw_c[i] == conf_q[i]) begin
          cnt_d[i] = '0;
        end else if (inc_c == lim_c) begin
          cnt_d[i]  = '0;
          conf_d[i] = ~conf_q[i];
        end else begin
          cnt_d[i] = inc_c;
        end
      end
    end
  end

  // Stage 2 state: counters and confirmed flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      conf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      conf_q <= conf_d;
    end
  end

  // Stage 3 next-state: LED selection, danger, alarm latch and onset counter.
  always_comb begin
    led_d       = '0;
    danger_d    = |conf_q;
    onset_c     = danger_d && !danger_q;
    alarm_d     = alarm_q;
    cnt_alarm_d = cnt_alarm_q;
    if (mode) begin
      led_d = conf_q;
    end else if (conf_q[3]) begin
      led_d[3] = 1'b1;
    end else if (conf_q[2]) begin
      led_d[2] = 1'b1;
    end else if (conf_q[1]) begin
      led_d[1] = 1'b1;
    end else if (conf_q[0]) begin
      led_d[0] = 1'b1;
    end
    if (onset_c) begin
      alarm_d = 1'b1;
      if (cnt_alarm_q != 8'hFF) cnt_alarm_d = cnt_alarm_q + 8'd1;
    end else if (ack && !danger_d) begin
      alarm_d = 1'b0;
    end
  end

  // Stage 3 state: output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q       <= '0;
      danger_q    <= 1'b0;
      alarm_q     <= 1'b0;
      cnt_alarm_q <= 8'd0;
    end else begin
      led_q       <= led_d;
      danger_q    <= danger_d;
      alarm_q     <= alarm_d;
      cnt_alarm_q <= cnt_alarm_d;
    end
  end

  assign flood_led      = led_q[0];
  assign cyclone_led    = led_q[1];
  assign earthquake_led = led_q[2];
  assign tsunami_led    = led_q[3];
  assign danger_led     = danger_q;
  assign safe_led       = ~danger_q;
  assign alarm          = alarm_q;
  assign alarm_count    = cnt_alarm_q;

endmodule

// File: tb/tb_disaster_monitor_seq.sv
// Directed self-checking bench for disaster_monitor_seq.
module tb_disaster_monitor_seq;

  localparam int unsigned DW = 7;

  logic          clk;
  logic          rst_n;
  logic          sample_valid;
  logic [DW-1:0] rain, seismic, wind, sea;
  logic          mode, ack;
  logic          flood_led, cyclone_led, earthquake_led, tsunami_led;
  logic          danger_led, safe_led, alarm;
  logic [7:0]    alarm_count;

  int checks;
  int failures;

  disaster_monitor_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid   (sample_valid),
    .rain           (rain),
    .seismic        (seismic),
    .wind           (wind),
    .sea            (sea),
    .mode           (mode),
    .ack            (ack),
    .flood_led      (flood_led),
    .cyclone_led    (cyclone_led),
    .earthquake_led (earthquake_led),
    .tsunami_led    (tsunami_led),
    .danger_led     (danger_led),
    .safe_led       (safe_led),
    .alarm          (alarm),
    .alarm_count    (alarm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [DW-1:0] r, input logic [DW-1:0] s,
                        input logic [DW-1:0] w, input logic [DW-1:0] l);
    rain = r; seismic = s; wind = w; sea = l;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    mode = 1'b1;
    ack = 1'b0;
    set_in(0, 0, 0, 0);
    #8;
    check_eq("rst_danger", danger_led, 0);
    check_eq("rst_safe", safe_led, 1);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_count", alarm_count, 0);
    #4 rst_n = 1'b1;

    // Persistence: flood + cyclone, first sample at edge 1, LEDs at edge 6.
    sample_valid = 1'b1;
    set_in(40, 0, 40, 0);
    step(5);
    check_eq("pers_flood_early", flood_led, 0);
    check_eq("pers_cyc_early", cyclone_led, 0);
    step(1);
    check_eq("pers_flood", flood_led, 1);
    check_eq("pers_cyc", cyclone_led, 1);
    check_eq("pers_eq", earthquake_led, 0);
    check_eq("pers_danger", danger_led, 1);
    check_eq("pers_safe", safe_led, 0);
    check_eq("pers_alarm", alarm, 1);
    check_eq("pers_count", alarm_count, 1);

    // Hysteresis: danger holds through CLEAR false samples; ack ignored during danger.
    set_in(0, 0, 0, 0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_eq("hyst_ack_ignored", alarm, 1);
    step(8);
    check_eq("hyst_hold", danger_led, 1);
    step(1);
    check_eq("hyst_clear", danger_led, 0);
    check_eq("hyst_safe", safe_led, 1);
    check_eq("hyst_alarm_latched", alarm, 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_eq("hyst_ack_clear", alarm, 0);
    check_eq("hyst_count", alarm_count, 1);

    // Broken streak with an invalid gap inside the second run.
    set_in(0, 5, 0, 0);
    step(3);
    set_in(0, 0, 0, 0);
    step(1);
    set_in(0, 5, 0, 0);
    step(2);
    sample_valid = 1'b0;
    step(2);
    sample_valid = 1'b1;
    step(1);
    check_eq("brk_mid", earthquake_led, 0);
    step(1);
    step(1);
    check_eq("brk_early", earthquake_led, 0);
    step(1);
    check_eq("brk_rise", earthquake_led, 1);
    set_in(0, 0, 0, 0);
    step(11);
    check_eq("brk_clear", danger_led, 0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_eq("brk_alarm", alarm, 0);
    check_eq("brk_count", alarm_count, 2);

    // UNIQUE priority.
    mode = 1'b0;
    set_in(40, 5, 40, 0);
    step(5);
    check_eq("uniq_early", earthquake_led, 0);
    step(1);
    check_eq("uniq_eq", earthquake_led, 1);
    check_eq("uniq_flood", flood_led, 0);
    check_eq("uniq_cyc", cyclone_led, 0);
    check_eq("uniq_ts", tsunami_led, 0);
    check_eq("uniq_count", alarm_count, 3);
    mode = 1'b1;
    step(1);
    check_eq("multi_flood", flood_led, 1);
    check_eq("multi_cyc", cyclone_led, 1);
    check_eq("multi_eq", earthquake_led, 1);
    mode = 1'b0;
    set_in(40, 5, 40, 25);
    step(6);
    check_eq("uniq_ts_on", tsunami_led, 1);
    check_eq("uniq_ts_eq", earthquake_led, 0);
    check_eq("uniq_ts_flood", flood_led, 0);
    set_in(0, 0, 0, 0);
    step(11);
    check_eq("uniq_none_leds", {flood_led, cyclone_led, earthquake_led, tsunami_led}, 0);
    check_eq("uniq_none_safe", safe_led, 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    mode = 1'b1;

    // Saturation: 300 confirm/clear cycles.
    for (int i = 0; i < 300; i++) begin
      set_in(0, 5, 0, 0);
      step(4);
      set_in(0, 0, 0, 0);
      step(8);
    end
    step(3);
    check_eq("sat_count", alarm_count, 255);
    check_eq("sat_danger", danger_led, 0);
    check_eq("sat_alarm", alarm, 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_eq("sat_ack", alarm, 0);

    // Onset coinciding with ack keeps alarm set.
    ack = 1'b1;
    set_in(0, 5, 0, 0);
    step(6);
    check_eq("coll_danger", danger_led, 1);
    check_eq("coll_alarm", alarm, 1);
    check_eq("coll_count", alarm_count, 255);
    ack = 1'b0;

    // Asynchronous reset mid-streak.
    set_in(40, 0, 40, 0);
    step(2);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_danger", danger_led, 0);
    check_eq("arst_safe", safe_led, 1);
    check_eq("arst_alarm", alarm, 0);
    check_eq("arst_count", alarm_count, 0);
    check_eq("arst_eq", earthquake_led, 0);
    #2 rst_n = 1'b1;
    step(5);
    check_eq("arst_restreak_early", flood_led, 0);
    step(1);
    check_eq("arst_restreak", flood_led, 1);
    check_eq("arst_count1", alarm_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
